// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared line/beat geometry, adaptor state type and line-alignment helper
package cacheline_adaptor_pkg;
    localparam int BEAT_WIDTH = 64;
    localparam int NUM_BEATS  = 4;
    localparam int LINE_WIDTH = BEAT_WIDTH * NUM_BEATS;
    localparam int ADDR_WIDTH = 32;
    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(LINE_BYTES - 1);
    endfunction
endpackage

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// cacheline_adaptor_line_beat_buffer: read line assembled beat by beat, write line loaded whole and served beat by beat
module cacheline_adaptor_line_beat_buffer
    import cacheline_adaptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic                  beat_we,
    input  logic [CNT_W-1:0]      beat_idx,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    output logic [LINE_WIDTH-1:0] rd_line,
    output logic [BEAT_WIDTH-1:0] wr_beat
);
    logic [LINE_WIDTH-1:0] wr_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_line <= '0;
            wr_line <= '0;
        end else begin
            if (load) wr_line <= load_line;
            if (beat_we) rd_line[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
        end
    end

    assign wr_beat = wr_line[beat_idx*BEAT_WIDTH +: BEAT_WIDTH];
endmodule

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cacheline read/write into a NUM_BEATS burst of BEAT_WIDTH beats
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] line_address,
    output logic [LINE_WIDTH-1:0] line_rdata,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  line_read,
    input  logic                  line_write,
    output logic                  line_resp,
    output logic [ADDR_WIDTH-1:0] burst_address,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    output logic                  burst_read,
    output logic                  burst_write,
    input  logic                  burst_resp
);
    adaptor_state_t   state;
    logic [CNT_W-1:0] count;
    logic             last;

    assign last = count == CNT_W'(NUM_BEATS - 1);

    cacheline_adaptor_line_beat_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (state == IDLE && line_write),
        .load_line (line_wdata),
        .beat_we   (state == READ && burst_resp),
        .beat_idx  (count),
        .beat_in   (burst_rdata),
        .rd_line   (line_rdata),
        .wr_beat   (burst_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            line_resp     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write || line_read) burst_address <= line_align(line_address);
                    if (line_write) begin
                        state       <= WRITE;
                        burst_write <= 1'b1;
                    end else if (line_read) begin
                        state      <= READ;
                        burst_read <= 1'b1;
                    end
                end
                READ, WRITE: if (burst_resp) begin
                    count <= last ? '0 : count + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        burst_read  <= 1'b0;
                        burst_write <= 1'b0;
                        line_resp   <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    line_resp <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @(posedge clk)
        if (!rst && state == IDLE)
            assert (!(line_read && line_write))
            else $warning("cacheline_adaptor: line_read and line_write both high, write takes priority");
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: randomized self-checking bench against a line/beat reference model
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ADDR_WIDTH-1:0] line_address = '0;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic [LINE_WIDTH-1:0] line_wdata = '0;
    logic                  line_read = 1'b0;
    logic                  line_write = 1'b0;
    logic                  line_resp;
    logic [ADDR_WIDTH-1:0] burst_address;
    logic [BEAT_WIDTH-1:0] burst_rdata = '0;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic                  burst_read;
    logic                  burst_write;
    logic                  burst_resp = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [255:0] rd_model = '0;
    logic [63:0]  beats [4];
    int gap_mode = 0;
    bit both = 1'b0;

    cacheline_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .line_address  (line_address),
        .line_rdata    (line_rdata),
        .line_wdata    (line_wdata),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_rdata   (burst_rdata),
        .burst_wdata   (burst_wdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int gaps();
        return gap_mode == 0 ? 0 : gap_mode == 1 ? 1 : int'($urandom_range(0, 2));
    endfunction

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] exp_a;
        int n;
        exp_a = addr & 32'hFFFF_FFE0;
        line_address = addr;
        line_read = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n = gaps();
            repeat (n) begin
                burst_resp = 1'b0;
                burst_rdata = {$urandom, $urandom};
                line_address = $urandom;
                checks++;
                if ({burst_read, burst_write, burst_address, line_resp} !== {1'b1, 1'b0, exp_a, 1'b0}) begin
                    failures++;
                    $display("FAIL read_gap beat%0d: got rd/wr/addr/resp=%b/%b/%h/%b want 1/0/%h/0", i, burst_read, burst_write, burst_address, line_resp, exp_a);
                end
                tick();
            end
            burst_resp = 1'b1;
            burst_rdata = beats[i];
            line_address = $urandom;
            checks++;
            if ({burst_read, burst_write, burst_address, line_resp} !== {1'b1, 1'b0, exp_a, 1'b0}) begin
                failures++;
                $display("FAIL read_beat%0d: got rd/wr/addr/resp=%b/%b/%h/%b want 1/0/%h/0", i, burst_read, burst_write, burst_address, line_resp, exp_a);
            end
            tick();
        end
        burst_resp = 1'b0;
        rd_model = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b100) begin
            failures++;
            $display("FAIL read_done: got resp/rd/wr=%b/%b/%b want 1/0/0", line_resp, burst_read, burst_write);
        end
        checks++;
        if (line_rdata !== rd_model) begin
            failures++;
            $display("FAIL read_data: got %h want %h", line_rdata, rd_model);
        end
        line_read = 1'b0;
        tick();
        checks++;
        if (line_resp !== 1'b0 || line_rdata !== rd_model) begin
            failures++;
            $display("FAIL read_after: got resp=%b data=%h want resp=0 data=%h", line_resp, line_rdata, rd_model);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data);
        logic [31:0] exp_a;
        logic [63:0] exp_b;
        int n;
        exp_a = addr & 32'hFFFF_FFE0;
        line_address = addr;
        line_wdata = data;
        line_write = 1'b1;
        line_read = both;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_b = data[i*64 +: 64];
            n = gaps();
            repeat (n) begin
                burst_resp = 1'b0;
                line_address = $urandom;
                line_wdata = {8{$urandom}};
                checks++;
                if ({burst_write, burst_read, burst_address, burst_wdata, line_resp} !== {1'b1, 1'b0, exp_a, exp_b, 1'b0}) begin
                    failures++;
                    $display("FAIL write_gap beat%0d: got wr/rd/addr/wdata/resp=%b/%b/%h/%h/%b want 1/0/%h/%h/0", i, burst_write, burst_read, burst_address, burst_wdata, line_resp, exp_a, exp_b);
                end
                tick();
            end
            burst_resp = 1'b1;
            line_address = $urandom;
            line_wdata = {8{$urandom}};
            checks++;
            if ({burst_write, burst_read, burst_address, burst_wdata, line_resp} !== {1'b1, 1'b0, exp_a, exp_b, 1'b0}) begin
                failures++;
                $display("FAIL write_beat%0d: got wr/rd/addr/wdata/resp=%b/%b/%h/%h/%b want 1/0/%h/%h/0", i, burst_write, burst_read, burst_address, burst_wdata, line_resp, exp_a, exp_b);
            end
            tick();
        end
        burst_resp = 1'b0;
        checks++;
        if ({line_resp, burst_write, burst_read} !== 3'b100) begin
            failures++;
            $display("FAIL write_done: got resp/wr/rd=%b/%b/%b want 1/0/0", line_resp, burst_write, burst_read);
        end
        checks++;
        if (line_rdata !== rd_model) begin
            failures++;
            $display("FAIL write_keeps_rdata: got %h want %h", line_rdata, rd_model);
        end
        line_write = 1'b0;
        line_read = 1'b0;
        tick();
        checks++;
        if ({line_resp, burst_write, burst_read} !== 3'b000) begin
            failures++;
            $display("FAIL write_after: got resp/wr/rd=%b/%b/%b want 0/0/0", line_resp, burst_write, burst_read);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({line_rdata, line_resp, burst_read, burst_write, burst_wdata, burst_address} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got resp/rd/wr=%b/%b/%b addr=%h wdata=%h want all 0", line_resp, burst_read, burst_write, burst_address, burst_wdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({line_resp, burst_read, burst_write, burst_address} !== '0) begin
            failures++;
            $display("FAIL reset_release: got resp/rd/wr=%b/%b/%b addr=%h want 0", line_resp, burst_read, burst_write, burst_address);
        end
    endtask

    task automatic test_read_consecutive;
        gap_mode = 0;
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        do_read(32'h0000_1234);
    endtask

    task automatic test_write_gaps;
        gap_mode = 1;
        do_write(32'h0000_BEEF, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    endtask

    task automatic test_back_to_back;
        gap_mode = 0;
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        do_read($urandom);
        do_write($urandom, {8{$urandom}});
        do_read($urandom);
    endtask

    task automatic test_simultaneous;
        gap_mode = 2;
        both = 1'b1;
        do_write(32'h8000_0040, {8{$urandom}});
        both = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        line_address = 32'h0000_5678;
        line_read = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            tick();
        end
        burst_resp = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        rd_model = '0;
        checks++;
        if ({line_rdata, line_resp, burst_read, burst_write, burst_wdata, burst_address} !== '0) begin
            failures++;
            $display("FAIL reset_mid_burst: got resp/rd/wr=%b/%b/%b addr=%h data=%h want all 0", line_resp, burst_read, burst_write, burst_address, line_rdata);
        end
        line_read = 1'b0;
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({line_resp, burst_read, burst_write} !== 3'b000) begin
                failures++;
                $display("FAIL reset_no_resp cycle%0d: got resp/rd/wr=%b/%b/%b want 0/0/0", i, line_resp, burst_read, burst_write);
            end
        end
        gap_mode = 2;
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        do_read(32'hCAFE_F00D);
    endtask

    task automatic test_stray_resp;
        for (int i = 0; i < 3; i++) begin
            burst_resp = 1'b1;
            burst_rdata = {$urandom, $urandom};
            line_address = $urandom;
            tick();
            checks++;
            if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== rd_model) begin
                failures++;
                $display("FAIL stray_resp cycle%0d: got resp/rd/wr=%b/%b/%b data=%h want 0/0/0 data=%h", i, line_resp, burst_read, burst_write, line_rdata, rd_model);
            end
        end
        burst_resp = 1'b0;
        gap_mode = 0;
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        do_read(32'h0000_0100);
    endtask

    task automatic test_random;
        gap_mode = 2;
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
                do_read($urandom);
            end else begin
                do_write($urandom, {8{$urandom}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_consecutive();
        test_write_gaps();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_burst();
        test_stray_resp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
